// File: rtl/rle_job_scheduler.sv
// Front-end scheduler for the RLE compression engine: queues host jobs, runs them one at a
// time through the engine's start/done handshake, and returns per-job results with a watchdog.
module rle_job_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [31:0]            job_msg_addr,
  input  logic [31:0]            job_msg_size,
  input  logic [31:0]            job_rle_addr,
  input  logic [TAG_W-1:0]       job_tag,
  output logic                   rle_start,
  output logic [31:0]            rle_message_addr,
  output logic [31:0]            rle_message_size,
  output logic [31:0]            rle_rle_addr,
  input  logic                   rle_done,
  input  logic [31:0]            rle_size_in,
  output logic                   eng_rst,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [TAG_W-1:0]       res_tag,
  output logic [31:0]            res_size,
  output logic                   res_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] queue_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_SETTLE, S_WAIT, S_FLUSH} state_e;

  typedef struct packed {
    logic [31:0]      msg_addr;
    logic [31:0]      msg_size;
    logic [31:0]      rle_addr;
    logic [TAG_W-1:0] tag;
  } job_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      size;
    logic             err;
  } res_t;

  job_t jq_mem [DEPTH];
  res_t rq_mem [DEPTH];

  state_e           state_q, state_d;
  logic [PW-1:0]    jq_wr_q, jq_rd_q, rq_wr_q, rq_rd_q;
  logic [CW-1:0]    jq_cnt_q, rq_cnt_q;
  logic [WW-1:0]    wd_q, wd_d;
  logic             flush_q, flush_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
  logic [31:0]      msg_addr_q, msg_addr_d, msg_size_q, msg_size_d, rle_addr_q, rle_addr_d;

  logic job_push, job_pop, res_push, res_pop;
  job_t job_in, head;
  res_t res_in, res_head;

  assign job_ready = (jq_cnt_q != FULL);
  assign job_push  = job_valid && job_ready;
  assign job_in    = '{msg_addr: job_msg_addr, msg_size: job_msg_size,
                       rle_addr: job_rle_addr, tag: job_tag};
  assign head      = jq_mem[jq_rd_q];
  assign res_head  = rq_mem[rq_rd_q];
  assign res_pop   = res_valid && res_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d    = state_q;
    wd_d       = wd_q;
    flush_d    = flush_q;
    cur_tag_d  = cur_tag_q;
    msg_addr_d = msg_addr_q;
    msg_size_d = msg_size_q;
    rle_addr_d = rle_addr_q;
    job_pop    = 1'b0;
    res_push   = 1'b0;
    res_in     = '0;
    case (state_q)
      S_IDLE: begin
        // Launch only with a free result slot, so the result FIFO can never overflow.
        if (jq_cnt_q != '0 && rq_cnt_q < FULL) begin
          job_pop   = 1'b1;
          cur_tag_d = head.tag;
          if (head.msg_size == '0) begin
            res_push   = 1'b1;
            res_in.tag = head.tag;
          end else begin
            msg_addr_d = head.msg_addr;
            msg_size_d = head.msg_size;
            rle_addr_d = head.rle_addr;
            state_d    = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_d = S_SETTLE;
      S_SETTLE: begin
        // The engine's previous done is still high here; it is ignored.
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rle_done) begin
          res_push    = 1'b1;
          res_in.tag  = cur_tag_q;
          res_in.size = rle_size_in;
          state_d     = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          flush_d = 1'b0;
          state_d = S_FLUSH;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_FLUSH: begin
        if (flush_q) begin
          res_push   = 1'b1;
          res_in.tag = cur_tag_q;
          res_in.err = 1'b1;
          state_d    = S_IDLE;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values, independent of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      jq_wr_q    <= '0;
      jq_rd_q    <= '0;
      jq_cnt_q   <= '0;
      rq_wr_q    <= '0;
      rq_rd_q    <= '0;
      rq_cnt_q   <= '0;
      wd_q       <= '0;
      flush_q    <= 1'b0;
      cur_tag_q  <= '0;
      msg_addr_q <= '0;
      msg_size_q <= '0;
      rle_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      flush_q    <= flush_d;
      cur_tag_q  <= cur_tag_d;
      msg_addr_q <= msg_addr_d;
      msg_size_q <= msg_size_d;
      rle_addr_q <= rle_addr_d;
      if (job_push) jq_wr_q <= jq_wr_q + PW'(1);
      if (job_pop)  jq_rd_q <= jq_rd_q + PW'(1);
      if (job_push != job_pop) jq_cnt_q <= job_push ? jq_cnt_q + CW'(1) : jq_cnt_q - CW'(1);
      if (res_push) rq_wr_q <= rq_wr_q + PW'(1);
      if (res_pop)  rq_rd_q <= rq_rd_q + PW'(1);
      if (res_push != res_pop) rq_cnt_q <= res_push ? rq_cnt_q + CW'(1) : rq_cnt_q - CW'(1);
    end
  end

  // NOTE: storage arrays carry no reset; the counters define validity and result outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (job_push) jq_mem[jq_wr_q] <= job_in;
    if (res_push) rq_mem[rq_wr_q] <= res_in;
  end

  assign rle_start        = (state_q == S_LAUNCH);
  assign rle_message_addr = msg_addr_q;
  assign rle_message_size = msg_size_q;
  assign rle_rle_addr     = rle_addr_q;
  assign eng_rst          = reset | (state_q == S_FLUSH);
  assign res_valid        = (rq_cnt_q != '0);
  assign res_tag          = res_valid ? res_head.tag  : '0;
  assign res_size         = res_valid ? res_head.size : '0;
  assign res_err          = res_valid ? res_head.err  : 1'b0;
  assign busy             = (state_q != S_IDLE) || (jq_cnt_q != '0);
  assign queue_count      = jq_cnt_q;

endmodule
